sseg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller for N common-anode digits. It replaces the fixed 4-digit refresh/anode/BCD chain in the board top-level. It adds full hex decode (0-F), per-digit decimal points, leading-zero blanking, PWM brightness, per-digit blink, and frame-synchronous input latching so displayed values never tear mid-frame. It sits between switch/user logic and the `sseg_anode`/`sseg_cathode` constraint pins.

---
 rtl/sseg_pkg.sv | 32 +++
 rtl/sseg_hex_decoder.sv | 9 +
 rtl/sseg_scan_ctrl.sv | 107 ++++++++++
 tb/tb_sseg_scan_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment constants and the active-low hex decode table.
package sseg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  function automatic logic [6:0] hex_to_seg(logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/sseg_hex_decoder.sv
// sseg_hex_decoder: combinational hex nibble to active-low a..g segments.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed common-anode scan with frame-latched inputs,
// leading-zero blanking, PWM brightness and per-digit blink.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 5000,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    lzb_en,
  output logic [NUM_DIGITS-1:0]   sseg_anode,
  output logic [7:0]              sseg_cathode,
  output logic                    frame_start
);
  localparam int SW = $clog2(DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int OW = SW + BRIGHT_W + 1;
  logic [SW-1:0]           slot_cnt;
  logic [DW-1:0]           digit_idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] digits_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic [NUM_DIGITS-1:0]   blink_s;
  logic [BRIGHT_W-1:0]     brightness_s;
  logic                    lzb_en_s;
  logic                    slot_wrap;
  logic                    frame_wrap;
  logic                    frame_last;
  logic [OW-1:0]           on_win;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lead;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic [7:0]              cathode_d;
  assign slot_wrap  = slot_cnt == SW'(DIV - 1);
  assign frame_wrap = slot_wrap && digit_idx == DW'(NUM_DIGITS - 1);
  assign frame_last = frame_cnt == FW'(BLINK_FRAMES - 1);
  // Full-width product so the top brightness code yields exactly DIV.
  assign on_win  = ((OW'(brightness_s) + OW'(1)) * OW'(DIV)) >> BRIGHT_W;
  assign cur_nib = digits_s[{digit_idx, 2'b00} +: 4];
  sseg_hex_decoder u_dec (
    .nibble(cur_nib),
    .seg   (seg)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt     <= '0;
      digit_idx    <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      digits_s     <= '0;
      dp_s         <= '0;
      blink_s      <= '0;
      brightness_s <= '0;
      lzb_en_s     <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
      if (frame_wrap) begin
        digits_s     <= digits;
        dp_s         <= dp;
        blink_s      <= blink;
        brightness_s <= brightness;
        lzb_en_s     <= lzb_en;
        frame_cnt    <= frame_last ? '0 : frame_cnt + 1'b1;
        if (frame_last) blink_phase <= ~blink_phase;
      end
    end
  end
  always_comb begin
    lead     = lzb_en_s;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead        = lead && (digits_s[4*i +: 4] == 4'h0);
      lz_blank[i] = lead;
    end
    lit       = (OW'(slot_cnt) < on_win) && !(blink_s[digit_idx] && blink_phase);
    anode_d   = lit ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
    cathode_d = SEG_BLANK;
    if (lit) begin
      cathode_d[SEG_DP]      = ~dp_s[digit_idx];
      cathode_d[SEG_G:SEG_A] = lz_blank[digit_idx] ? 7'h7F : seg;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sseg_anode   <= '1;
      sseg_cathode <= SEG_BLANK;
      frame_start  <= 1'b0;
    end else begin
      sseg_anode   <= anode_d;
      sseg_cathode <= cathode_d;
      frame_start  <= slot_cnt == '0 && digit_idx == '0;
    end
  end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: directed scan checks with 4 digits, 16-clock slots, 2-frame blink.
module tb_sseg_scan_ctrl;
  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blink;
  logic [3:0]  brightness;
  logic        lzb_en;
  logic [3:0]  sseg_anode;
  logic [7:0]  sseg_cathode;
  logic        frame_start;
  int checks;
  int failures;
  int cyc;
  int lit_n;
  sseg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIV         (16),
    .BRIGHT_W    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .dp          (dp),
    .blink       (blink),
    .brightness  (brightness),
    .lzb_en      (lzb_en),
    .sseg_anode  (sseg_anode),
    .sseg_cathode(sseg_cathode),
    .frame_start (frame_start)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic chk(input string tag, input logic [3:0] a, input logic [7:0] c, input logic fs);
    checks++;
    assert (sseg_anode === a && sseg_cathode === c && frame_start === fs)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d got anode=%b cathode=%h fs=%b expected anode=%b cathode=%h fs=%b",
             tag, cyc, sseg_anode, sseg_cathode, frame_start, a, c, fs);
    end
  endtask
  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset = 1'b1; digits = '0; dp = '0; blink = '0; brightness = '0; lzb_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 4'b1111, 8'hFF, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    digits = 16'hA5F0; dp = 4'b0100; brightness = 4'd15;
    to(1);   chk("f0_d0_min", 4'b1110, 8'hC0, 1'b1);
    to(2);   chk("f0_d0_dim", 4'b1111, 8'hFF, 1'b0);
    to(17);  chk("f0_d1",     4'b1101, 8'hC0, 1'b0);
    to(64);  chk("f0_end",    4'b1111, 8'hFF, 1'b0);
    to(65);  chk("f1_d0",     4'b1110, 8'hC0, 1'b1);
    to(80);  chk("f1_d0_end", 4'b1110, 8'hC0, 1'b0);
    to(81);  chk("f1_d1",     4'b1101, 8'h8E, 1'b0);
    to(97);  chk("f1_d2_dp",  4'b1011, 8'h12, 1'b0);
    to(113); chk("f1_d3",     4'b0111, 8'h88, 1'b0);
    to(128); chk("f1_d3_end", 4'b0111, 8'h88, 1'b0);
    to(129); chk("f2_start",  4'b1110, 8'hC0, 1'b1);
    to(130);
    digits = 16'h1234;
    to(145); chk("midframe_hold", 4'b1101, 8'h8E, 1'b0);
    to(193); chk("f3_d0_new",     4'b1110, 8'h99, 1'b1);
    to(209); chk("f3_d1_new",     4'b1101, 8'hB0, 1'b0);
    lzb_en = 1'b1; digits = 16'h0030; dp = 4'b0000;
    to(257); chk("lzb_d0", 4'b1110, 8'hC0, 1'b1);
    to(273); chk("lzb_d1", 4'b1101, 8'hB0, 1'b0);
    to(289); chk("lzb_d2", 4'b1011, 8'hFF, 1'b0);
    to(305); chk("lzb_d3", 4'b0111, 8'hFF, 1'b0);
    digits = 16'h0000; dp = 4'b0100;
    to(321); chk("lzb0_d0",    4'b1110, 8'hC0, 1'b1);
    to(337); chk("lzb0_d1",    4'b1101, 8'hFF, 1'b0);
    to(353); chk("lzb0_d2_dp", 4'b1011, 8'h7F, 1'b0);
    to(369); chk("lzb0_d3",    4'b0111, 8'hFF, 1'b0);
    brightness = 4'd7; lzb_en = 1'b0; dp = 4'b0000;
    to(392); chk("b7_last_on", 4'b1110, 8'hC0, 1'b0);
    to(393); chk("b7_off",     4'b1111, 8'hFF, 1'b0);
    to(400);
    lit_n = 0;
    for (int k = 0; k < 16; k++) begin
      to(401 + k);
      if (sseg_anode != 4'b1111) lit_n++;
    end
    checks++;
    assert (lit_n == 8)
    else begin
      failures++;
      $error("FAIL b7_width got %0d clocks expected 8", lit_n);
    end
    blink = 4'b0001; brightness = 4'd15;
    to(449); chk("blink_f7_d0",  4'b1111, 8'hFF, 1'b1);
    to(465); chk("blink_f7_d1",  4'b1101, 8'hC0, 1'b0);
    to(513); chk("blink_f8_d0",  4'b1110, 8'hC0, 1'b1);
    to(577); chk("blink_f9_d0",  4'b1110, 8'hC0, 1'b1);
    to(641); chk("blink_f10_d0", 4'b1111, 8'hFF, 1'b1);
    to(705); chk("blink_f11_d0", 4'b1111, 8'hFF, 1'b1);
    to(721); chk("blink_f11_d1", 4'b1101, 8'hC0, 1'b0);
    reset = 1'b1;
    #2;
    chk("async_reset", 4'b1111, 8'hFF, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    to(1);   chk("rst2_f0_d0",  4'b1110, 8'hC0, 1'b1);
    to(2);   chk("rst2_f0_dim", 4'b1111, 8'hFF, 1'b0);
    to(65);  chk("rst2_f1_lit", 4'b1110, 8'hC0, 1'b1);
    to(129); chk("rst2_f2_dark", 4'b1111, 8'hFF, 1'b1);
    to(193); chk("rst2_f3_dark", 4'b1111, 8'hFF, 1'b1);
    to(257); chk("rst2_f4_lit", 4'b1110, 8'hC0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
